pf_vf_route_stage: RTL and testbench

- Pipelined routing stage directly upstream of the PF/VF MUX switch fabric.
- Accepts a packet stream tagged with PF/VF/vf_active on its first beat and looks the tag up in a runtime-programmable routing table.
- First valid matching entry wins; PF and VF fields may be wildcards.
- Forwards every beat with the resolved MUX port index so the downstream MUX can steer it without further decode.

---
 rtl/pf_vf_route_stage.sv | 150 +++++++++++++++
 tb/tb_pf_vf_route_stage.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pf_vf_route_stage.sv
// PF/VF routing stage: resolves a MUX port per packet from a programmable
// match table on the first beat and forwards every beat through one register stage.
module pf_vf_route_stage #(
  parameter int NUM_ENTRIES  = 8,
  parameter int NUM_PORTS    = 4,
  parameter int PF_WIDTH     = 3,
  parameter int VF_WIDTH     = 11,
  parameter int DATA_WIDTH   = 512,
  parameter int DEFAULT_PORT = 0,
  localparam int PORT_W      = $clog2(NUM_PORTS),
  localparam int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic [PF_WIDTH-1:0]   in_pf,
  input  logic [VF_WIDTH-1:0]   in_vf,
  input  logic                  in_vf_active,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [PORT_W-1:0]     out_port,
  output logic                  out_miss,
  input  logic                  tbl_wr_en,
  input  logic [IDX_W-1:0]      tbl_wr_idx,
  input  logic                  tbl_wr_valid,
  input  logic [PORT_W-1:0]     tbl_wr_port,
  input  logic [PF_WIDTH-1:0]   tbl_wr_pf,
  input  logic                  tbl_wr_pf_any,
  input  logic [VF_WIDTH-1:0]   tbl_wr_vf,
  input  logic                  tbl_wr_vf_any,
  input  logic                  tbl_wr_vf_active,
  output logic [15:0]           miss_cnt
);

  localparam logic [0:0] ST_SOP  = 1'b0;
  localparam logic [0:0] ST_BODY = 1'b1;

  logic [NUM_ENTRIES-1:0]             w_hit;
  logic [NUM_ENTRIES-1:0][PORT_W-1:0] w_port;
  logic [PORT_W-1:0]                  w_lk_port;
  logic                               w_lk_miss;
  logic [PORT_W-1:0]                  w_route_port;
  logic                               w_route_miss;
  logic                               w_accept;

  logic [0:0]            r_state;
  logic [PORT_W-1:0]     r_route_port;
  logic                  r_route_miss;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_last;
  logic [PORT_W-1:0]     r_out_port;
  logic                  r_out_miss;
  logic [15:0]           r_miss_cnt;

  // Each entry compares against the live request; writes land on the next edge,
  // so a same-cycle lookup always sees the old contents.
  for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
    logic                r_valid;
    logic [PORT_W-1:0]   r_port;
    logic [PF_WIDTH-1:0] r_pf;
    logic                r_pf_any;
    logic [VF_WIDTH-1:0] r_vf;
    logic                r_vf_any;
    logic                r_vf_active;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid     <= 1'b0;
        r_port      <= '0;
        r_pf        <= '0;
        r_pf_any    <= 1'b0;
        r_vf        <= '0;
        r_vf_any    <= 1'b0;
        r_vf_active <= 1'b0;
      end else if (tbl_wr_en && (tbl_wr_idx == IDX_W'(gi))) begin
        r_valid     <= tbl_wr_valid;
        r_port      <= tbl_wr_port;
        r_pf        <= tbl_wr_pf;
        r_pf_any    <= tbl_wr_pf_any;
        r_vf        <= tbl_wr_vf;
        r_vf_any    <= tbl_wr_vf_any;
        r_vf_active <= tbl_wr_vf_active;
      end
    end

    assign w_hit[gi]  = r_valid && (r_vf_active == in_vf_active) &&
                        (r_pf_any || (r_pf == in_pf)) &&
                        (r_vf_any || (r_vf == in_vf));
    assign w_port[gi] = r_port;
  end

  // Scan from the top so the lowest-index hit is the last assignment.
  always_comb begin
    w_lk_port = PORT_W'(DEFAULT_PORT);
    w_lk_miss = 1'b1;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_lk_port = w_port[i];
        w_lk_miss = 1'b0;
      end
    end
  end

  assign w_route_port = (r_state == ST_SOP) ? w_lk_port : r_route_port;
  assign w_route_miss = (r_state == ST_SOP) ? w_lk_miss : r_route_miss;
  assign in_ready     = !r_out_valid || out_ready;
  assign w_accept     = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_SOP;
      r_route_port <= '0;
      r_route_miss <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_last   <= 1'b0;
      r_out_port   <= '0;
      r_out_miss   <= 1'b0;
      r_miss_cnt   <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= in_data;
      r_out_last  <= in_last;
      r_out_port  <= w_route_port;
      r_out_miss  <= w_route_miss;
      if (r_state == ST_SOP) begin
        r_route_port <= w_lk_port;
        r_route_miss <= w_lk_miss;
        if (w_lk_miss && (r_miss_cnt != 16'hFFFF)) r_miss_cnt <= r_miss_cnt + 16'd1;
      end
      r_state <= in_last ? ST_SOP : ST_BODY;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_port  = r_out_port;
  assign out_miss  = r_out_miss;
  assign miss_cnt  = r_miss_cnt;

endmodule

// File: tb/tb_pf_vf_route_stage.sv
// Scoreboard bench for pf_vf_route_stage: a driver predicts each beat from a
// table-based reference model, a monitor pops and compares on every output transfer.
module tb_pf_vf_route_stage;
  localparam int NE = 8;
  localparam int DW = 512;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0, in_ready, in_last = 1'b0, in_vf_active = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [2:0]    in_pf = '0;
  logic [10:0]   in_vf = '0;
  logic          out_valid, out_ready = 1'b1, out_last, out_miss;
  logic [DW-1:0] out_data;
  logic [1:0]    out_port;
  logic          tbl_wr_en = 1'b0, tbl_wr_valid = 1'b0, tbl_wr_pf_any = 1'b0;
  logic          tbl_wr_vf_any = 1'b0, tbl_wr_vf_active = 1'b0;
  logic [2:0]    tbl_wr_idx = '0, tbl_wr_pf = '0;
  logic [1:0]    tbl_wr_port = '0;
  logic [10:0]   tbl_wr_vf = '0;
  logic [15:0]   miss_cnt;

  pf_vf_route_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .in_pf(in_pf), .in_vf(in_vf), .in_vf_active(in_vf_active),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_port(out_port), .out_miss(out_miss),
    .tbl_wr_en(tbl_wr_en), .tbl_wr_idx(tbl_wr_idx), .tbl_wr_valid(tbl_wr_valid),
    .tbl_wr_port(tbl_wr_port), .tbl_wr_pf(tbl_wr_pf), .tbl_wr_pf_any(tbl_wr_pf_any),
    .tbl_wr_vf(tbl_wr_vf), .tbl_wr_vf_any(tbl_wr_vf_any),
    .tbl_wr_vf_active(tbl_wr_vf_active), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v; bit [1:0] port; bit [2:0] pf; bit pf_any; bit [10:0] vf; bit vf_any; bit vfa;
  } ent_t;
  typedef struct {
    logic [DW-1:0] data; logic last; logic [1:0] port; logic miss; logic [15:0] cnt;
  } exp_t;

  ent_t        m_tbl[NE];
  exp_t        sb[$];
  bit          m_in_pkt;
  logic [1:0]  m_port;
  logic        m_miss;
  int unsigned m_cnt;
  bit          wr_pend;
  ent_t        wr_ent;
  int          wr_idx;
  int          n_cmp = 0, n_bad = 0, n_beat = 0;
  bit          quiet = 1'b0;
  int          rdy_mode = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic ent_t mk(bit v, bit [1:0] port, bit [2:0] pf, bit pf_any,
                              bit [10:0] vf, bit vf_any, bit vfa);
    ent_t e;
    e.v = v; e.port = port; e.pf = pf; e.pf_any = pf_any;
    e.vf = vf; e.vf_any = vf_any; e.vfa = vfa;
    return e;
  endfunction

  // Reference rule: first valid entry whose fields all agree wins.
  function automatic void lookup(input bit [2:0] pf, input bit [10:0] vf, input bit vfa,
                                 output logic [1:0] port, output logic miss);
    port = 2'd0;
    miss = 1'b1;
    for (int i = 0; i < NE; i++) begin
      if (m_tbl[i].v && m_tbl[i].vfa == vfa && (m_tbl[i].pf_any || m_tbl[i].pf == pf) &&
          (m_tbl[i].vf_any || m_tbl[i].vf == vf)) begin
        port = m_tbl[i].port;
        miss = 1'b0;
        return;
      end
    end
  endfunction

  task automatic model_reset();
    sb.delete();
    m_in_pkt = 1'b0;
    m_cnt    = 0;
    wr_pend  = 1'b0;
    for (int i = 0; i < NE; i++) m_tbl[i] = mk(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic set_wr(input int idx, input ent_t e);
    tbl_wr_en = 1'b1; tbl_wr_idx = 3'(idx); tbl_wr_valid = e.v; tbl_wr_port = e.port;
    tbl_wr_pf = e.pf; tbl_wr_pf_any = e.pf_any; tbl_wr_vf = e.vf;
    tbl_wr_vf_any = e.vf_any; tbl_wr_vf_active = e.vfa;
    wr_pend = 1'b1; wr_ent = e; wr_idx = idx;
  endtask

  // Called just after each rising edge: a pending write has now landed.
  task automatic apply_wr();
    if (wr_pend) begin
      m_tbl[wr_idx] = wr_ent;
      wr_pend = 1'b0;
    end
    tbl_wr_en = 1'b0;
  endtask

  task automatic tbl_write(input int idx, input ent_t e);
    set_wr(idx, e);
    @(posedge clk); #1;
    apply_wr();
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input bit last, input bit [2:0] pf,
                           input bit [10:0] vf, input bit vfa);
    in_valid = 1'b1; in_data = d; in_last = last; in_pf = pf; in_vf = vf; in_vf_active = vfa;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (in_ready) break;
      if (t > 200) begin
        n_cmp++; n_bad++;
        $display("FAIL accept_timeout: got in_ready=0 for %0d cycles expected 1", t);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      apply_wr();
    end
    if (!m_in_pkt) begin
      lookup(pf, vf, vfa, m_port, m_miss);
      if (m_miss && m_cnt < 32'hFFFF) m_cnt++;
    end
    m_in_pkt = !last;
    sb.push_back('{d, last, m_port, m_miss, m_cnt[15:0]});
    @(posedge clk); #1;
    apply_wr();
    in_valid = 1'b0;
  endtask

  // Only the first beat carries a meaningful tag; later beats get random garbage.
  task automatic send_pkt(input int nb, input bit [2:0] pf, input bit [10:0] vf, input bit vfa);
    for (int b = 0; b < nb; b++) begin
      if (b == 0) send_beat(rand_data(), nb == 1, pf, vf, vfa);
      else send_beat(rand_data(), b == nb - 1, 3'($urandom), 11'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int pi = 0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: begin out_ready = pat[pi]; pi = (pi + 1) % 4; end
      endcase
    end
  end

  initial begin
    bit   stalled = 1'b0;
    exp_t held, e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
        continue;
      end
      chk("in_ready_rule", in_ready, !out_valid || out_ready);
      if (stalled) begin
        chk("stall_data", out_data, held.data);
        chk("stall_last", out_last, held.last);
        chk("stall_port", out_port, held.port);
        chk("stall_miss", out_miss, held.miss);
      end
      if (out_valid && out_ready) begin
        stalled = 1'b0;
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL extra_beat: got port=%0d with no beat outstanding", out_port);
        end else begin
          e = sb.pop_front();
          chk("data", out_data, e.data);
          chk("last", out_last, e.last);
          chk("port", out_port, e.port);
          chk("miss", out_miss, e.miss);
          chk("miss_cnt", miss_cnt, e.cnt);
          n_beat++;
          if (!quiet)
            $display("beat %0d: port=%0d miss=%0d last=%0d miss_cnt=%0d",
                     n_beat, out_port, out_miss, out_last, miss_cnt);
        end
      end else if (out_valid) begin
        stalled = 1'b1;
        held = '{out_data, out_last, out_port, out_miss, miss_cnt};
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_port", out_port, 0);
    chk("rst_out_miss", out_miss, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Empty table: miss to the default port, visible one cycle after accept.
    send_pkt(1, 3'd1, 11'd0, 1'b0);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_port", out_port, 0);
    chk("t1_out_miss", out_miss, 1);
    chk("t1_miss_cnt", miss_cnt, 1);

    tbl_write(2, mk(1, 2'd3, 3'd1, 0, 11'd0, 1, 1));
    tbl_write(5, mk(1, 2'd2, 3'd0, 1, 11'd0, 1, 1));
    send_pkt(1, 3'd1, 11'd7, 1'b1);
    send_pkt(1, 3'd4, 11'd7, 1'b1);
    send_pkt(1, 3'd1, 11'd7, 1'b0);

    // Rewrite entry 2 during beat 2 of a 4-beat packet; route must not change.
    send_beat(rand_data(), 0, 3'd1, 11'd7, 1'b1);
    set_wr(2, mk(1, 2'd1, 3'd1, 0, 11'd0, 1, 1));
    send_beat(rand_data(), 0, 3'd6, 11'd99, 1'b0);
    send_beat(rand_data(), 0, 3'd4, 11'd5, 1'b0);
    send_beat(rand_data(), 1, 3'd0, 11'd3, 1'b1);
    // SOP lookup concurrent with a write sees the old entry.
    set_wr(2, mk(1, 2'd3, 3'd1, 0, 11'd0, 1, 1));
    send_pkt(2, 3'd1, 11'd7, 1'b1);
    send_pkt(1, 3'd1, 11'd7, 1'b1);

    rdy_mode = 2;
    for (int p = 0; p < 6; p++)
      send_pkt($urandom_range(1, 3), 3'($urandom_range(0, 7)), 11'd7, 1'($urandom_range(0, 1)));

    rdy_mode = 1;
    for (int p = 0; p < 80; p++) begin
      if ($urandom_range(0, 3) == 0)
        set_wr($urandom_range(0, NE - 1),
               mk(1'($urandom_range(0, 3) != 0), 2'($urandom), 3'($urandom), 1'($urandom),
                  11'($urandom_range(0, 3)), 1'($urandom), 1'($urandom)));
      send_pkt($urandom_range(1, 4), 3'($urandom), 11'($urandom_range(0, 3)), 1'($urandom));
    end

    // Drive the miss counter to saturation with an empty table.
    rdy_mode = 0;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < NE; i++) tbl_write(i, mk(0, 0, 0, 0, 0, 0, 0));
    quiet = 1'b1;
    while (m_cnt < 32'hFFFE) send_beat(rand_data(), 1, 3'($urandom), 11'($urandom), 1'b0);
    chk("cnt_fffe", miss_cnt, 16'hFFFE);
    quiet = 1'b0;
    for (int i = 0; i < 3; i++) send_pkt(1, 3'd2, 11'd9, 1'b0);
    chk("cnt_sat", miss_cnt, 16'hFFFF);

    // Reset in the middle of a 3-beat packet.
    tbl_write(5, mk(1, 2'd2, 3'd0, 1, 11'd0, 1, 1));
    send_beat(rand_data(), 0, 3'd3, 11'd1, 1'b0);
    in_valid = 1'b1; in_data = rand_data(); in_last = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_out_port", out_port, 0);
    chk("arst_out_miss", out_miss, 0);
    chk("arst_miss_cnt", miss_cnt, 0);
    in_valid = 1'b0;
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    tbl_write(2, mk(1, 2'd3, 3'd1, 0, 11'd0, 1, 1));
    tbl_write(5, mk(1, 2'd2, 3'd0, 1, 11'd0, 1, 1));
    send_pkt(1, 3'd4, 11'd7, 1'b1);
    chk("post_rst_port", out_port, 2);
    chk("post_rst_miss", out_miss, 0);

    repeat (6) @(posedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
